// File: rtl/binario_a_bcd_secuencial_pkg.sv
// rtl/binario_a_bcd_secuencial_pkg.sv - shared types and constants for the binary to BCD converter
package binario_a_bcd_secuencial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } estado_t;

  localparam int N_DIG        = 4;
  localparam int BCD_W        = 4;
  localparam int MAX_VAL_4DIG = 9999;

  localparam logic [BCD_W-1:0] ADD3_UMBRAL = 4'd5;

endpackage

// File: rtl/ajuste_digito_bcd.sv
// rtl/ajuste_digito_bcd.sv - add-3 correction of one BCD nibble before each shift
module ajuste_digito_bcd
  import binario_a_bcd_secuencial_pkg::*;
(
  input  logic [BCD_W-1:0] i_Digito,
  output logic [BCD_W-1:0] o_Digito
);

  always_comb begin
    o_Digito = i_Digito;
    if (i_Digito >= ADD3_UMBRAL) begin
      o_Digito = i_Digito + BCD_W'(3);
    end
  end

endmodule

// File: rtl/binario_a_bcd_secuencial.sv
// rtl/binario_a_bcd_secuencial.sv - sequential shift-and-add-3 converter feeding the 4-digit display
module binario_a_bcd_secuencial
  import binario_a_bcd_secuencial_pkg::*;
#(
  parameter int N_BITS  = 14,
  parameter int MAX_VAL = MAX_VAL_4DIG
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic [N_BITS-1:0] i_Binario,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Ovf,
  output logic [BCD_W-1:0]  o_Digito1,
  output logic [BCD_W-1:0]  o_Digito2,
  output logic [BCD_W-1:0]  o_Digito3,
  output logic [BCD_W-1:0]  o_Digito4
);

  localparam int                CNT_W   = $clog2(N_BITS);
  localparam int                ACC_W   = N_DIG * BCD_W;
  localparam logic [CNT_W-1:0]  CNT_ULT = CNT_W'(N_BITS - 1);
  localparam logic [N_BITS-1:0] MAX_BIN = N_BITS'(MAX_VAL);

  estado_t             estado_q, estado_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_BITS-1:0]   bin_q, bin_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [ACC_W-1:0]    dig_q, dig_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  logic [ACC_W-1:0]        acc_aj;
  logic [ACC_W+N_BITS-1:0] desplazado;

  for (genvar g = 0; g < N_DIG; g++) begin : g_ajuste
    ajuste_digito_bcd u_ajuste (
      .i_Digito (acc_q[g*BCD_W +: BCD_W]),
      .o_Digito (acc_aj[g*BCD_W +: BCD_W])
    );
  end

  // Corrected accumulator and remaining binary bits shift as one register.
  assign desplazado = {acc_aj, bin_q} << 1;

  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    ovf_pend_d = ovf_pend_q;
    dig_d      = dig_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (estado_q)
      ST_IDLE: begin
        if (i_Start) begin
          bin_d      = i_Binario;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (i_Binario > MAX_BIN);
          estado_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = desplazado[ACC_W+N_BITS-1:N_BITS];
        bin_d = desplazado[N_BITS-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_ULT) begin
          estado_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        // Saturated inputs show 9999 so the display never wraps silently.
        dig_d    = ovf_pend_q ? {N_DIG{BCD_W'(9)}} : acc_q;
        ovf_d    = ovf_pend_q;
        done_d   = 1'b1;
        estado_d = ST_IDLE;
      end
      default: estado_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      estado_q   <= ST_IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      acc_q      <= '0;
      ovf_pend_q <= 1'b0;
      dig_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      ovf_pend_q <= ovf_pend_d;
      dig_q      <= dig_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign o_Busy    = (estado_q != ST_IDLE);
  assign o_Done    = done_q;
  assign o_Ovf     = ovf_q;
  assign o_Digito1 = dig_q[0*BCD_W +: BCD_W];
  assign o_Digito2 = dig_q[1*BCD_W +: BCD_W];
  assign o_Digito3 = dig_q[2*BCD_W +: BCD_W];
  assign o_Digito4 = dig_q[3*BCD_W +: BCD_W];

endmodule

// File: tb/tb_binario_a_bcd_secuencial.sv
// tb/tb_binario_a_bcd_secuencial.sv - scoreboard bench for the sequential binary to BCD converter
module tb_binario_a_bcd_secuencial;

  localparam int NB = 14;

  logic          clk = 1'b0;
  logic          i_Rst = 1'b1;
  logic          i_Start = 1'b0;
  logic [NB-1:0] i_Binario = '0;
  logic          o_Busy, o_Done, o_Ovf;
  logic [3:0]    o_Digito1, o_Digito2, o_Digito3, o_Digito4;

  binario_a_bcd_secuencial dut (
    .i_Clk     (clk),
    .i_Rst     (i_Rst),
    .i_Start   (i_Start),
    .i_Binario (i_Binario),
    .o_Busy    (o_Busy),
    .o_Done    (o_Done),
    .o_Ovf     (o_Ovf),
    .o_Digito1 (o_Digito1),
    .o_Digito2 (o_Digito2),
    .o_Digito3 (o_Digito3),
    .o_Digito4 (o_Digito4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dig;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          acc_cyc = -1000;
  logic [15:0] shown = 16'h0000;
  logic        shown_ovf = 1'b0;
  bit          mon_en = 1'b0;
  bit          chk_vacio = 1'b0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [15:0] ref_dig(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic void push_exp(input int v, input int a);
    exp_t e;
    e.dig = ref_dig(v);
    e.ovf = (v > 9999);
    e.cyc = a + 15;
    sb.push_back(e);
  endfunction

  // Monitor: compares DUT outputs against the scoreboard on every falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic        exp_busy;
      logic [15:0] got;
      exp_t        e;
      got      = {o_Digito4, o_Digito3, o_Digito2, o_Digito1};
      exp_busy = (cyc >= acc_cyc) && (cyc <= acc_cyc + 14);
      total++;
      if (o_Busy !== exp_busy) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, o_Busy, exp_busy);
      end
      if (o_Done === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done cyc=%0d got=1 exp=0", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc != e.cyc) begin
            bad++;
            $display("FAIL done_latency got_cyc=%0d exp_cyc=%0d", cyc, e.cyc);
          end
          total++;
          if (got !== e.dig || o_Ovf !== e.ovf) begin
            bad++;
            $display("FAIL result cyc=%0d got=%h ovf=%b exp=%h ovf=%b", cyc, got, o_Ovf, e.dig, e.ovf);
          end
          shown     = e.dig;
          shown_ovf = e.ovf;
        end
      end else begin
        total++;
        if (got !== shown || o_Ovf !== shown_ovf || o_Done !== 1'b0) begin
          bad++;
          $display("FAIL hold cyc=%0d got=%h ovf=%b done=%b exp=%h ovf=%b done=0",
                   cyc, got, o_Ovf, o_Done, shown, shown_ovf);
        end
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
          total++;
          bad++;
          $display("FAIL missing_done cyc=%0d got=0 exp_at=%0d", cyc, sb[0].cyc);
          void'(sb.pop_front());
        end
      end
      if (chk_vacio) begin
        chk_vacio = 1'b0;
        total++;
        if (sb.size() != 0) begin
          bad++;
          $display("FAIL leftover got=%0d exp=0", sb.size());
        end
      end
    end
  end

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic do_conv(input int v, input int gap, input bit poke, input int k, input int pbin);
    int a;
    i_Start   = 1'b1;
    i_Binario = NB'(v);
    @(posedge clk);
    #1;
    a       = cyc;
    acc_cyc = a;
    push_exp(v, a);
    i_Start = 1'b0;
    while (cyc < a + 15) begin
      @(negedge clk);
      i_Start   = poke && (cyc == a + k);
      i_Binario = i_Start ? NB'(pbin) : NB'($urandom);
    end
    i_Start = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int a;
    int v;
    repeat (3) @(negedge clk);
    i_Rst  = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    do_conv(0, 2, 1'b0, 0, 0);
    do_conv(1234, 0, 1'b0, 0, 0);
    do_conv(9999, 1, 1'b0, 0, 0);
    do_conv(10000, 0, 1'b0, 0, 0);
    do_conv(16383, 0, 1'b0, 0, 0);
    do_conv(42, 3, 1'b0, 0, 0);

    // Reset sampled at E8 of a 4321 conversion abandons it.
    i_Start   = 1'b1;
    i_Binario = NB'(4321);
    @(posedge clk);
    #1;
    a       = cyc;
    acc_cyc = a;
    i_Start = 1'b0;
    while (cyc < a + 7) @(negedge clk);
    i_Rst = 1'b1;
    @(posedge clk);
    #1;
    i_Rst     = 1'b0;
    acc_cyc   = -1000;
    shown     = 16'h0000;
    shown_ovf = 1'b0;
    repeat (3) @(negedge clk);

    do_conv(77, 2, 1'b0, 0, 0);
    do_conv(5678, 1, 1'b1, 6, 1111);

    // Held-high start: back-to-back conversions every 16 clocks.
    i_Start   = 1'b1;
    i_Binario = NB'(1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      a       = cyc;
      acc_cyc = a;
      push_exp(i + 1, a);
      if (i == 2) i_Start = 1'b0;
      while (cyc < a + 15) @(negedge clk);
      if (i < 2) i_Binario = NB'(i + 2);
    end
    repeat (2) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      do_conv(v, int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
              int'($urandom_range(0, 14)), int'($urandom_range(0, 16383)));
    end

    for (int w = 0; w < 40 && sb.size() != 0; w++) @(negedge clk);
    #1;
    chk_vacio = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
